// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: two-requester round-robin IR frame scheduler.
// Sequences leader mark/space, 8 pulse-distance data bits (LSB first),
// a stop mark and an inter-frame gap, and gates its own carrier onto
// the LED drive pin. All outputs are registered.
module ir_tx_scheduler #(
  parameter int unsigned CAR_P0     = 32'd800,
  parameter int unsigned CAR_P1     = 32'd600,
  parameter int unsigned CAR_P2     = 32'd400,
  parameter int unsigned LEAD_MARK  = 32'd243000,
  parameter int unsigned LEAD_SPACE = 32'd121500,
  parameter int unsigned BIT_MARK   = 32'd15120,
  parameter int unsigned ZERO_SPACE = 32'd15120,
  parameter int unsigned ONE_SPACE  = 32'd45360,
  parameter int unsigned GAP        = 32'd1080000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] code0,
  input  logic [7:0] code1,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  input  logic       abort,
  output logic [1:0] ack,
  output logic       busy,
  output logic       done,
  output logic       TX_RX_signal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LMARK  = 3'd1,
    LSPACE = 3'd2,
    BMARK  = 3'd3,
    BSPACE = 3'd4,
    SMARK  = 3'd5,
    GAPW   = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] dur_r, dur_s;
  logic [31:0] car_r, car_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  code_r, code_s;
  logic [1:0]  sel_r, sel_s;
  logic        rr_last_r, rr_last_s;
  logic [1:0]  ack_s;
  logic        busy_s, done_s, tx_s;
  logic [31:0] len_s, per_s, half_s;
  logic        last_s, is_mark_s, abort_hit_s, grant_s;

  // Carrier period for a select code; select 3 shares the fastest carrier.
  function automatic logic [31:0] car_period(input logic [1:0] sel);
    case (sel)
      2'd0:    car_period = CAR_P0;
      2'd1:    car_period = CAR_P1;
      default: car_period = CAR_P2;
    endcase
  endfunction

  assign per_s       = car_period(sel_r);
  assign half_s      = per_s >> 1;
  assign is_mark_s   = (state_r == LMARK) || (state_r == BMARK) || (state_r == SMARK);
  assign abort_hit_s = abort && (state_r != IDLE) && (state_r != GAPW);
  assign last_s      = (dur_r == (len_s - 32'd1));
  // Lone requester wins outright; on a tie the one not served last wins.
  assign grant_s     = (req == 2'b10) ? 1'b1 : ((req == 2'b11) ? ~rr_last_r : 1'b0);

  // Length of the current timed state; the space after a bit depends on that bit.
  always_comb begin
    case (state_r)
      LMARK:        len_s = LEAD_MARK;
      LSPACE:       len_s = LEAD_SPACE;
      BMARK, SMARK: len_s = BIT_MARK;
      BSPACE:       len_s = code_r[idx_r] ? ONE_SPACE : ZERO_SPACE;
      GAPW:         len_s = GAP;
      default:      len_s = 32'd1;
    endcase
  end

  // State register plus registered outputs; reset puts everything idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      dur_r        <= 32'd0;
      car_r        <= 32'd0;
      idx_r        <= 3'd0;
      code_r       <= 8'd0;
      sel_r        <= 2'd0;
      rr_last_r    <= 1'b1;
      ack          <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      TX_RX_signal <= 1'b0;
    end else begin
      state_r      <= state_s;
      dur_r        <= dur_s;
      car_r        <= car_s;
      idx_r        <= idx_s;
      code_r       <= code_s;
      sel_r        <= sel_s;
      rr_last_r    <= rr_last_s;
      ack          <= ack_s;
      busy         <= busy_s;
      done         <= done_s;
      TX_RX_signal <= tx_s;
    end
  end

  // Next-state logic: grant, timed-state advance, carrier wrap and abort.
  always_comb begin
    state_s   = state_r;
    dur_s     = dur_r;
    car_s     = car_r;
    idx_s     = idx_r;
    code_s    = code_r;
    sel_s     = sel_r;
    rr_last_s = rr_last_r;
    if (abort_hit_s) begin
      state_s = GAPW;
      dur_s   = 32'd0;
      car_s   = 32'd0;
      idx_s   = 3'd0;
    end else if (state_r == IDLE) begin
      if (req != 2'b00) begin
        state_s   = LMARK;
        dur_s     = 32'd0;
        car_s     = 32'd0;
        idx_s     = 3'd0;
        code_s    = grant_s ? code1 : code0;
        sel_s     = grant_s ? sel1 : sel0;
        rr_last_s = grant_s;
      end else begin
        state_s = IDLE;
      end
    end else if (last_s) begin
      dur_s = 32'd0;
      car_s = 32'd0;
      case (state_r)
        LMARK:   state_s = LSPACE;
        LSPACE:  state_s = BMARK;
        BMARK:   state_s = BSPACE;
        BSPACE:  begin
          state_s = (idx_r < 3'd7) ? BMARK : SMARK;
          idx_s   = idx_r + 3'd1;
        end
        SMARK:   state_s = GAPW;
        GAPW:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end else begin
      dur_s = dur_r + 32'd1;
      if (is_mark_s) begin
        car_s = (car_r == (per_s - 32'd1)) ? 32'd0 : (car_r + 32'd1);
      end else begin
        car_s = 32'd0;
      end
    end
  end

  // Output values for the next cycle: ack/done pulses, busy, gated carrier.
  always_comb begin
    ack_s = 2'b00;
    if ((state_r == IDLE) && (req != 2'b00)) begin
      ack_s[grant_s] = 1'b1;
    end else begin
      ack_s = 2'b00;
    end
    done_s = (state_r == SMARK) && last_s && !abort_hit_s;
    busy_s = (state_s != IDLE);
    tx_s   = !abort_hit_s && is_mark_s && (car_r < half_s);
  end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// tb_ir_tx_scheduler: directed, table-driven bench for ir_tx_scheduler
// using shortened timing so whole frames fit in a few hundred cycles.
module tb_ir_tx_scheduler;

  localparam int LM = 20, LS = 10, BM = 4, ZS = 4, OS = 12, GP = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] code0 = 8'h00, code1 = 8'h00;
  logic [1:0] sel0 = 2'd0, sel1 = 2'd0;
  logic       abort = 1'b0;
  logic [1:0] ack;
  logic       busy, done, TX_RX_signal;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  ir_tx_scheduler #(
    .CAR_P0(32'd4), .CAR_P1(32'd6), .CAR_P2(32'd2),
    .LEAD_MARK(32'd20), .LEAD_SPACE(32'd10), .BIT_MARK(32'd4),
    .ZERO_SPACE(32'd4), .ONE_SPACE(32'd12), .GAP(32'd30)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .code0(code0), .code1(code1),
    .sel0(sel0), .sel1(sel1), .abort(abort), .ack(ack), .busy(busy),
    .done(done), .TX_RX_signal(TX_RX_signal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] req;
    logic [7:0] code;
    logic [1:0] sel;
    logic [1:0] exp_ack;
    int         per;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait (bounded) for any ack; returns the cycle it was seen in, -1 on timeout.
  task automatic wait_ack(output int at);
    int w;
    w = 0;
    while (ack == 2'b00 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (ack == 2'b00) begin
      nchk++;
      nerr++;
      $display("FAIL ack_timeout: got no ack expected one within 400 cycles");
      at = -1;
    end else begin
      at = cyc;
    end
  endtask

  // Runs one full frame from its ack through the end of the gap and checks
  // the expected carrier waveform, done timing and busy timing.
  task automatic run_frame(input logic [1:0] exp_ack, input logic [7:0] code,
                           input int per, input bit drop, output int ack_at);
    bit mk [0:511];
    int len, at, e_tx, e_busy, e_done, e_ack;
    logic first_tx, first_busy, first_done, first_ack;
    len = 0;
    for (int k = 0; k < LM; k++) begin mk[len] = ((k % per) < (per / 2)); len++; end
    for (int k = 0; k < LS; k++) begin mk[len] = 1'b0; len++; end
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < BM; k++) begin mk[len] = ((k % per) < (per / 2)); len++; end
      for (int k = 0; k < (code[b] ? OS : ZS); k++) begin mk[len] = 1'b0; len++; end
    end
    for (int k = 0; k < BM; k++) begin mk[len] = ((k % per) < (per / 2)); len++; end
    wait_ack(at);
    ack_at = at;
    if (at < 0) return;
    check("ack_value", 32'(ack), 32'(exp_ack));
    if (drop) req = 2'b00;
    e_tx = 0; e_busy = 0; e_done = 0; e_ack = 0;
    for (int t = 0; t <= len + GP; t++) begin
      first_tx   = (t == 0) ? 1'b0 : ((t <= len) ? mk[t-1] : 1'b0);
      first_done = (t == len);
      first_busy = (t < len + GP);
      first_ack  = 1'b0;
      if (TX_RX_signal !== first_tx && e_tx == 0) begin
        e_tx = 1;
        $display("FAIL tx_wave: got %0b expected %0b at frame cycle %0d", TX_RX_signal, first_tx, t);
      end
      if (done !== first_done && e_done == 0) begin
        e_done = 1;
        $display("FAIL done_timing: got %0b expected %0b at frame cycle %0d", done, first_done, t);
      end
      if (busy !== first_busy && e_busy == 0) begin
        e_busy = 1;
        $display("FAIL busy_timing: got %0b expected %0b at frame cycle %0d", busy, first_busy, t);
      end
      if (t > 0 && ack !== 2'b00 && e_ack == 0) begin
        e_ack = 1;
        $display("FAIL ack_pulse: got %0d expected %0d at frame cycle %0d", ack, first_ack, t);
      end
      if (t < len + GP) @(negedge clk);
    end
    nchk += 4;
    nerr += e_tx + e_done + e_busy + e_ack;
  endtask

  initial begin
    int a0, a1, a2, c0, ca;
    // 0xA5 -> spaces 12,4,12,4,4,12,4,12 -> frame 20+10+32+64+4 = 130
    vecs[0] = '{req: 2'b01, code: 8'hA5, sel: 2'd0, exp_ack: 2'b01, per: 4};
    vecs[1] = '{req: 2'b01, code: 8'hFF, sel: 2'd2, exp_ack: 2'b01, per: 2};
    vecs[2] = '{req: 2'b01, code: 8'h81, sel: 2'd3, exp_ack: 2'b01, per: 2};
    vecs[3] = '{req: 2'b10, code: 8'h00, sel: 2'd2, exp_ack: 2'b10, per: 2};
    vecs[4] = '{req: 2'b10, code: 8'h3C, sel: 2'd1, exp_ack: 2'b10, per: 6};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx", 32'(TX_RX_signal), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Single-requester frames from the table.
    for (int i = 0; i < 5; i++) begin
      req = vecs[i].req;
      if (vecs[i].req[0]) begin code0 = vecs[i].code; sel0 = vecs[i].sel; end
      else begin code1 = vecs[i].code; sel1 = vecs[i].sel; end
      run_frame(vecs[i].exp_ack, vecs[i].code, vecs[i].per, 1'b1, a0);
      repeat (2) @(negedge clk);
    end

    // Both asking for three frames: last winner was 1, so order is 0,1,0.
    // Next ack comes one cycle after the first IDLE cycle: frame + GAP + 1.
    code0 = 8'hA5; sel0 = 2'd0; code1 = 8'h3C; sel1 = 2'd1;
    req = 2'b11;
    run_frame(2'b01, 8'hA5, 4, 1'b0, a0);
    run_frame(2'b10, 8'h3C, 6, 1'b0, a1);
    run_frame(2'b01, 8'hA5, 4, 1'b1, a2);
    check("rr_spacing0", 32'(a1 - a0), 32'(130 + GP + 1));
    check("rr_spacing1", 32'(a2 - a1), 32'(LM + LS + 8 * BM + 4 * OS + 4 * ZS + BM + GP + 1));
    repeat (2) @(negedge clk);

    // Abort in the second cycle of the third bit mark (frame cycle 47).
    code1 = 8'h00; sel1 = 2'd0;
    req = 2'b11;
    wait_ack(c0);
    check("abort_ack", 32'(ack), 32'd2);
    req = 2'b01;
    repeat (47) @(negedge clk);
    check("pre_abort_tx", 32'(TX_RX_signal), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_tx", 32'(TX_RX_signal), 32'd0);
    for (int t = 48; t < 78; t++) begin
      if (t == 60) abort = 1'b1;
      if (t == 61) abort = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1 || TX_RX_signal !== 1'b0) begin
        check("abort_gap", {29'd0, done, busy, TX_RX_signal}, 32'd2);
      end
      @(negedge clk);
    end
    check("abort_busy_fall", 32'(busy), 32'd0);
    run_frame(2'b01, 8'hA5, 4, 1'b1, ca);
    check("abort_regrant", 32'(ca - c0), 32'd79);
    repeat (2) @(negedge clk);

    // Reset mid-leader-space with both asking: requester 0 must win after.
    code0 = 8'h00; sel0 = 2'd0;
    req = 2'b01;
    wait_ack(c0);
    repeat (25) @(negedge clk);
    req = 2'b11;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_tx", 32'(TX_RX_signal), 32'd0);
    check("async_rst_ack", 32'(ack), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_frame(2'b01, 8'h00, 4, 1'b1, a0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
